port_rx: RTL and testbench
==========================

PORT_RX -- requirements
Module: port_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of parsed-packet entries (power of two, >=2).
REQ-002 The block SHALL have port clock  input  1  single rising-edge clock for all logic.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port frame_n  input  1  serial frame, low while a packet is on the link.
REQ-005 The block SHALL have port valid_n  input  1  serial payload-bit valid, active low.
REQ-006 The block SHALL have port di  input  1  serial data bit.
REQ-007 The block SHALL have port pkt_valid  output  1  head FIFO entry available.
REQ-008 The block SHALL have port pkt_ready  input  1  fabric accepts head entry.
REQ-009 The block SHALL have port pkt_da  output  3  destination port of head entry.
REQ-010 The block SHALL have port pkt_data  output  32  payload of head entry, bit 0 = first received.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse on a protocol error or overflow drop.

Function
REQ-012 Sampling SHALL use the rising clock edge; cycle N = first sampled frame_n low following a sampled frame_n high.
REQ-013 The FSM SHALL use states IDLE, ADDR, PAD, DATA, DROP.
REQ-014 IDLE: on frame_n falling (frame_n low, previous sample high) -> capture di as da[0], go to ADDR.
REQ-015 ADDR: capture da[1] at N+1 and da[2] at N+2, then go to PAD; PAD ignores di for exactly one cycle (N+3), then go to DATA.
REQ-016 DATA: each cycle with valid_n low SHALL shift di into payload bit k (k = 0..31); cycles with valid_n high and frame_n low are stalls.
REQ-017 The last bit is the one sampled with valid_n low and frame_n high; if k==31 the packet is complete, else err pulses (short packet), packet dropped, go to IDLE.
REQ-018 Bit k==31 sampled with frame_n still low -> err pulses (long packet), go to DROP; DROP returns to IDLE when frame_n sampled high.
REQ-019 frame_n high with valid_n high in ADDR, PAD or DATA -> abort: err pulses, packet dropped, go to IDLE.
REQ-020 valid_n low in ADDR or PAD -> err pulses, go to DROP.
REQ-021 A complete packet SHALL be written {da, payload} into the FIFO on the edge that samples the last bit; pkt_valid asserts the next cycle (latency 1 cycle).
REQ-022 FIFO SHALL be show-ahead: pkt_valid = not empty; pkt_da/pkt_data reflect head; pop on pkt_valid & pkt_ready.
REQ-023 Push when full with no simultaneous pop -> packet dropped, err pulses; push and pop in the same cycle when full -> both succeed, occupancy unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL emerge in arrival order.
REQ-025 pkt_da/pkt_data SHALL be stable while pkt_valid is high and pkt_ready low.
REQ-026 At most one err pulse SHALL be produced per packet.

Reset
REQ-027 reset_n low SHALL asynchronously force FSM to IDLE, FIFO empty, pkt_valid=0, pkt_da=0, pkt_data=0, err=0, the previous-frame_n register=0, shift state cleared.
REQ-028 After reset release, a packet already in progress (frame_n low) SHALL be ignored until frame_n is sampled high.

Configuration
REQ-029 With macro PORT_RX_STATS_EN defined, outputs rx_pkt_cnt [7:0] (packets written to FIFO) and rx_drop_cnt [7:0] (err pulses) SHALL exist, saturate at 255, and reset to 0.
REQ-030 Without PORT_RX_STATS_EN, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-031 Single packet da=7, payload 32'hdeadbeef, pkt_ready=1 -> pkt_valid high one cycle after last bit, pkt_da=7, pkt_data=32'hdeadbeef, err never asserted.
REQ-032 Eight back-to-back packets da=0..7 with 10 idle cycles between, pkt_ready=0 until all sent, FIFO_DEPTH=4 -> first 4 held in order, packets 5-8 each pulse err; on pkt_ready=1, da 0,1,2,3 emerge in order.
REQ-033 Payload with valid_n high for 3 stall cycles between bits 15 and 16 -> payload reassembled correctly, no err.
REQ-034 frame_n rises with bit 19 (20 bits) -> one err pulse, no FIFO write; next well-formed packet 32'h12341234 received intact.
REQ-035 reset_n pulsed low during payload bit 10, then remainder of that packet continues -> no pkt_valid, no err; following packet da=3, 32'hcafecafe received correctly.
REQ-036 With PORT_RX_STATS_EN, 2 good packets and 1 aborted packet -> rx_pkt_cnt=2, rx_drop_cnt=1.

Source files
------------

// File: rtl/port_rx.sv
// port_rx: serial packet receiver. Deserialises a 3-bit destination and a
// 32-bit payload from the frame_n/valid_n/di link. Complete packets go into a
// show-ahead FIFO that the fabric drains through pkt_valid/pkt_ready.
// Protocol errors and overflow drops raise a one-cycle err pulse.
// Optional feature: define PORT_RX_STATS_EN to add saturating packet and
// drop counters (rx_pkt_cnt, rx_drop_cnt).
module port_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_n,
    input  logic        valid_n,
    input  logic        di,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [2:0]  pkt_da,
    output logic [31:0] pkt_data,
    output logic        err
`ifdef PORT_RX_STATS_EN
    ,
    output logic [7:0]  rx_pkt_cnt,
    output logic [7:0]  rx_drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} state_t;

    state_t      state;
    logic        frame_n_p1;
    logic [2:0]  da;
    logic        addr_hi;
    logic [30:0] shreg;
    logic [4:0]  bit_cnt;

    logic [2:0]  mem_da   [FIFO_DEPTH];
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic        full, pop, push_req, push, overflow;
    logic [31:0] push_data;

    // Head of the FIFO drives the fabric side directly (show-ahead).
    always_comb begin
        full      = (count == DEPTH_C);
        pkt_valid = (count != '0);
        pop       = pkt_valid & pkt_ready;
        pkt_da    = mem_da[rd_ptr];
        pkt_data  = mem_data[rd_ptr];
        push_req  = (state == DATA) && !valid_n && frame_n && (bit_cnt == 5'd31);
        push_data = {di, shreg};
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = push_req && (!full || pop);
        overflow  = push_req && full && !pop;
    end

    // Link-side FSM: address capture, pad skip, payload shift, error pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_n_p1 <= 1'b0;
            da         <= '0;
            addr_hi    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            frame_n_p1 <= frame_n;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    // frame_n_p1 resets low, so a packet already running at
                    // reset release is ignored until frame_n is seen high.
                    if (!frame_n && frame_n_p1) begin
                        da[0]   <= di;
                        addr_hi <= 1'b0;
                        state   <= ADDR;
                    end
                end
                ADDR, PAD: begin
                    if (!valid_n) begin
                        err   <= 1'b1;
                        state <= DROP;
                    end else if (frame_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (state == ADDR) begin
                        if (addr_hi) begin
                            da[2] <= di;
                            state <= PAD;
                        end else begin
                            da[1]   <= di;
                            addr_hi <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (!valid_n) begin
                        if (bit_cnt != 5'd31) begin
                            shreg[bit_cnt] <= di;
                        end
                        if (frame_n) begin
                            // Last bit: short packet or FIFO overflow both drop.
                            state <= IDLE;
                            if (bit_cnt != 5'd31 || overflow) begin
                                err <= 1'b1;
                            end
                        end else if (bit_cnt == 5'd31) begin
                            err   <= 1'b1;
                            state <= DROP;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (frame_n) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (frame_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packet FIFO storage and pointers; entries are {da, payload}.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_da[i]   <= '0;
                mem_data[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_da[wr_ptr]   <= da;
                mem_data[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

`ifdef PORT_RX_STATS_EN
    // Saturating counters of accepted packets and err pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_pkt_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (push && rx_pkt_cnt != 8'hff) begin
                rx_pkt_cnt <= rx_pkt_cnt + 8'd1;
            end
            if (err && rx_drop_cnt != 8'hff) begin
                rx_drop_cnt <= rx_drop_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_port_rx.sv
// Scoreboard bench for port_rx: stimulus pushes expected {da, payload}
// entries; a negedge monitor pops and compares whenever a packet is taken.
module tb_port_rx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_n = 1'b1;
    logic        valid_n = 1'b1;
    logic        di = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        pkt_valid;
    logic [2:0]  pkt_da;
    logic [31:0] pkt_data;
    logic        err;
`ifdef PORT_RX_STATS_EN
    logic [7:0]  rx_pkt_cnt;
    logic [7:0]  rx_drop_cnt;
`endif

    port_rx #(.FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .di        (di),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_da    (pkt_da),
        .pkt_data  (pkt_data),
        .err       (err)
`ifdef PORT_RX_STATS_EN
        ,
        .rx_pkt_cnt  (rx_pkt_cnt),
        .rx_drop_cnt (rx_drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [34:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        frame_n = 1'b1;
        valid_n = 1'b1;
        di      = 1'b0;
        repeat (n) tick();
    endtask

    // Serialise one packet. stall_at: bit index preceded by 3 stall cycles.
    // abort: last bit keeps frame_n low so the following idle aborts.
    // pop_last: pkt_ready high only during the last-bit cycle.
    // rst_at: bit index during which reset_n is pulsed low.
    task automatic send(input logic [2:0] da, input logic [31:0] data, input int nbits,
                        input int stall_at, input bit abort, input bit pop_last, input int rst_at);
        frame_n = 1'b0; valid_n = 1'b1;
        di = da[0]; tick();
        di = da[1]; tick();
        di = da[2]; tick();
        di = 1'b0;  tick();
        for (int k = 0; k < nbits; k++) begin
            if (k == stall_at) begin
                valid_n = 1'b1;
                repeat (3) tick();
            end
            valid_n = 1'b0;
            di      = data[k % 32];
            frame_n = (k == nbits - 1 && !abort) ? 1'b1 : 1'b0;
            if (pop_last && k == nbits - 1) pkt_ready = 1'b1;
            if (k == rst_at) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            tick();
            if (pop_last && k == nbits - 1) pkt_ready = 1'b0;
        end
        frame_n = 1'b1; valid_n = 1'b1; di = 1'b0;
    endtask

    task automatic drain();
        pkt_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        pkt_ready = 1'b0;
        tick();
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_pkt_valid", pkt_valid, 1'b0);
    endtask

    // Monitor: count err pulses and score every accepted packet.
    always @(negedge clock) begin
        if (reset_n) begin
            if (err) err_seen++;
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pkt: got da=%0h data=%0h expected none", pkt_da, pkt_data);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    check("pkt_da", pkt_da, e[34:32]);
                    check("pkt_data", pkt_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_da", pkt_da, 3'd0);
        check("rst_pkt_data", pkt_data, 32'd0);
        check("rst_err", err, 1'b0);
        reset_n = 1'b1;
        idle(3);

        // Single packet, 1-cycle latency
        pkt_ready = 1'b1;
        exp_q.push_back({3'd7, 32'hdeadbeef});
        send(3'd7, 32'hdeadbeef, 32, -1, 0, 0, -1);
        check("latency_pkt_valid", pkt_valid, 1'b1);
        check("latency_pkt_da", pkt_da, 3'd7);
        idle(5);
        check("err_after_single", err_seen, exp_err);

        // Stall between bits 15 and 16
        exp_q.push_back({3'd5, 32'h8001_7ffe});
        send(3'd5, 32'h8001_7ffe, 32, 16, 0, 0, -1);
        idle(5);
        check("err_after_stall", err_seen, exp_err);

        // Short packet then a good one
        exp_err++;
        send(3'd2, 32'hffff_ffff, 20, -1, 0, 0, -1);
        idle(5);
        check("err_after_short", err_seen, exp_err);
        exp_q.push_back({3'd4, 32'h1234_1234});
        send(3'd4, 32'h1234_1234, 32, -1, 0, 0, -1);
        idle(5);
        check("err_after_recover", err_seen, exp_err);
        check("queue_after_recover", exp_q.size(), 0);

        // Abort in DATA, then long packet
        exp_err++;
        send(3'd1, 32'h0f0f_0f0f, 10, -1, 1, 0, -1);
        idle(5);
        check("err_after_abort", err_seen, exp_err);
        exp_err++;
        send(3'd6, 32'h5a5a_5a5a, 34, -1, 0, 0, -1);
        idle(5);
        check("err_after_long", err_seen, exp_err);

        // Eight packets into a depth-4 FIFO with no pops
        pkt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) exp_q.push_back({3'(i), 32'ha5a5_0000 + 32'(i)});
            else exp_err++;
            send(3'(i), 32'ha5a5_0000 + 32'(i), 32, -1, 0, 0, -1);
            idle(10);
        end
        check("err_after_overflow", err_seen, exp_err);
        check("full_pkt_valid", pkt_valid, 1'b1);
        check("full_head_da", pkt_da, 3'd0);
        check("full_head_data", pkt_data, 32'ha5a5_0000);
        drain();

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({3'(i), 32'hc0de_0000 + 32'(i)});
            send(3'(i), 32'hc0de_0000 + 32'(i), 32, -1, 0, 0, -1);
            idle(3);
        end
        exp_q.push_back({3'd5, 32'h5555_aaaa});
        send(3'd5, 32'h5555_aaaa, 32, -1, 0, 1, -1);
        idle(3);
        check("err_after_full_pushpop", err_seen, exp_err);
        check("full_pushpop_head", pkt_da, 3'd1);
        drain();

        // Reset pulse during payload bit 10
        send(3'd2, 32'hffff_0000, 32, -1, 0, 0, 10);
        idle(5);
        check("reset_mid_pkt_valid", pkt_valid, 1'b0);
        check("err_after_reset_mid", err_seen, exp_err);
        pkt_ready = 1'b1;
        exp_q.push_back({3'd3, 32'hcafe_cafe});
        send(3'd3, 32'hcafe_cafe, 32, -1, 0, 0, -1);
        idle(5);
        check("queue_after_reset_pkt", exp_q.size(), 0);
        check("err_after_reset_pkt", err_seen, exp_err);

`ifdef PORT_RX_STATS_EN
        // Counters: two good packets and one abort after a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle(3);
        check("stats_rst_pkt", rx_pkt_cnt, 8'd0);
        exp_q.push_back({3'd1, 32'h1111_1111});
        send(3'd1, 32'h1111_1111, 32, -1, 0, 0, -1);
        idle(3);
        exp_err++;
        send(3'd2, 32'h2222_2222, 12, -1, 1, 0, -1);
        idle(3);
        exp_q.push_back({3'd3, 32'h3333_3333});
        send(3'd3, 32'h3333_3333, 32, -1, 0, 0, -1);
        idle(5);
        check("stats_pkt_cnt", rx_pkt_cnt, 8'd2);
        check("stats_drop_cnt", rx_drop_cnt, 8'd1);
`endif

        pkt_ready = 1'b0;
        idle(3);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_count", err_seen, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
